// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Optional MEX_FROM_MONT_EN adds a final acc*1 multiplication so the result leaves the Montgomery domain.
module mod_exp_ctrl #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           len,
  input  logic [7:0]           exp_len,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     base_m,
  input  logic [WIDTH-1:0]     one_m,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [7:0]           mm_len,
  output logic [WIDTH-1:0]     mm_modulus,
  input  logic                 mm_done,
  input  logic [WIDTH-1:0]     mm_result,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 err,
  output logic [7:0]           mm_count
);

  localparam int         IW      = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [8:0] EXP_MAX = 9'(EXP_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ_ISS,
    S_SQ_WAIT,
    S_MU_ISS,
    S_MU_WAIT,
`ifdef MEX_FROM_MONT_EN
    S_CV_ISS,
    S_CV_WAIT,
`endif
    S_FIN
  } state_t;

  state_t               r_state;
  logic [7:0]           r_len;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [WIDTH-1:0]     r_base;
  logic [WIDTH-1:0]     r_mod;
  logic [WIDTH-1:0]     r_acc;
  logic [7:0]           r_idx;
  logic                 r_bad;
  logic                 r_mm_start;
  logic [WIDTH-1:0]     r_mm_a;
  logic [WIDTH-1:0]     r_mm_b;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [WIDTH-1:0]     r_result;
  logic [7:0]           r_mm_count;

  logic                 w_bit;
  logic                 w_last;
  logic                 w_exp_bad;

  assign w_bit     = r_exp[r_idx[IW-1:0]];
  assign w_last    = (r_idx == 8'd0);
  assign w_exp_bad = ({1'b0, exp_len} > EXP_MAX);

  assign mm_start   = r_mm_start;
  assign mm_a       = r_mm_a;
  assign mm_b       = r_mm_b;
  assign mm_len     = r_len;
  assign mm_modulus = r_mod;
  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign err        = r_err;
  assign mm_count   = r_mm_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_exp      <= '0;
      r_base     <= '0;
      r_mod      <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_bad      <= 1'b0;
      r_mm_start <= 1'b0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_result   <= '0;
      r_mm_count <= '0;
    end else begin
      // NOTE: pulse outputs default low here and are overridden later in the same block;
      // with non-blocking assignments the last write wins, so no else-branches are needed.
      r_mm_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The done cycle itself is not an accept slot; a new start is taken the cycle after.
          if (start && !r_done) begin
            r_len      <= len;
            r_exp      <= exponent;
            r_base     <= base_m;
            r_mod      <= modulus;
            r_acc      <= one_m;
            r_idx      <= exp_len - 8'd1;
            r_mm_count <= 8'd0;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_bad      <= w_exp_bad;
            if (w_exp_bad) begin
              r_acc   <= '0;
              r_state <= S_FIN;
            end else if (exp_len == 8'd0) begin
`ifdef MEX_FROM_MONT_EN
              r_mm_a     <= one_m;
              r_mm_b     <= WIDTH'(1);
              r_mm_start <= 1'b1;
              r_mm_count <= 8'd1;
              r_state    <= S_CV_ISS;
`else
              r_state    <= S_FIN;
`endif
            end else begin
              r_mm_a     <= one_m;
              r_mm_b     <= one_m;
              r_mm_start <= 1'b1;
              r_mm_count <= 8'd1;
              r_state    <= S_SQ_ISS;
            end
          end
        end

        S_SQ_ISS: r_state <= S_SQ_WAIT;
        S_MU_ISS: r_state <= S_MU_WAIT;

        S_SQ_WAIT, S_MU_WAIT: begin
          if (mm_done) begin
            r_acc <= mm_result;
            if (r_state == S_SQ_WAIT && w_bit) begin
              r_mm_a     <= mm_result;
              r_mm_b     <= r_base;
              r_mm_start <= 1'b1;
              r_mm_count <= r_mm_count + 8'd1;
              r_state    <= S_MU_ISS;
            end else if (w_last) begin
`ifdef MEX_FROM_MONT_EN
              r_mm_a     <= mm_result;
              r_mm_b     <= WIDTH'(1);
              r_mm_start <= 1'b1;
              r_mm_count <= r_mm_count + 8'd1;
              r_state    <= S_CV_ISS;
`else
              r_state    <= S_FIN;
`endif
            end else begin
              r_idx      <= r_idx - 8'd1;
              r_mm_a     <= mm_result;
              r_mm_b     <= mm_result;
              r_mm_start <= 1'b1;
              r_mm_count <= r_mm_count + 8'd1;
              r_state    <= S_SQ_ISS;
            end
          end
        end

`ifdef MEX_FROM_MONT_EN
        S_CV_ISS: r_state <= S_CV_WAIT;

        S_CV_WAIT: begin
          if (mm_done) begin
            r_acc   <= mm_result;
            r_state <= S_FIN;
          end
        end
`endif

        S_FIN: begin
          r_result <= r_acc;
          r_err    <= r_bad;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
